graphite_cmd_bridge: RTL and testbench



---
 rtl/graphite_cmd_bridge.sv | 199 +++++++++++++++++++
 tb/tb_graphite_cmd_bridge.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/graphite_cmd_bridge.sv
// graphite_cmd_bridge: CPU sel/wr/ack register bus -> command FIFO -> AXI-stream
// master feeding the xga command port. Status readback, flush, sticky overflow
// and a low-water interrupt let software batch command submission.
// Optional feature macro: GRAPHITE_CMD_BRIDGE_WAITSTATE_EN
//   defined   : a DATA write to a full FIFO stalls in WAIT (ack withheld) until space.
//   undefined : a DATA write to a full FIFO is dropped and overflow is set.
module graphite_cmd_bridge #(
  parameter int DEPTH     = 16,
  parameter int LOW_WATER = 4
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        sel_i,
  input  logic        wr_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        ack_o,
  output logic        cmd_axis_tvalid_o,
  input  logic        cmd_axis_tready_i,
  output logic [31:0] cmd_axis_tdata_o,
  output logic        irq_o
);

  // The output stage holds one word, so the RAM only needs DEPTH-1 entries.
  localparam int RAM_DEPTH = DEPTH - 1;
  localparam int PTR_W     = $clog2(RAM_DEPTH);
  localparam int LVL_W     = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(LOW_WATER);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAM_DEPTH - 1);

`ifdef GRAPHITE_CMD_BRIDGE_WAITSTATE_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACK = 2'd1, ST_WAIT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACK = 2'd1} state_t;
`endif

  state_t           state_reg, state_next;
  logic [31:0]      mem [0:RAM_DEPTH-1];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [LVL_W-1:0] ram_cnt_reg, ram_cnt_next;
  logic [LVL_W-1:0] level, level_next;
  logic             tvalid_reg, tvalid_next;
  logic [31:0]      tdata_reg;
  logic             ovf_reg, ovf_next;
  logic             irq_en_reg, irq_en_next;
  logic             irq_reg;
  logic [31:0]      dout_reg, dout_next;

  logic take;        // bus access takes effect on this edge
  logic is_data_wr;
  logic do_pop, can_push, do_push;
  logic ctrl_wr, flush;
  logic refill, load_ram, load_byp, ram_we;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // level counts RAM words plus the output stage; RAM non-empty implies tvalid.
  assign level      = ram_cnt_reg + LVL_W'(tvalid_reg);
  assign do_pop     = tvalid_reg & cmd_axis_tready_i;
  assign can_push   = (level < LVL_FULL) | do_pop;
  assign is_data_wr = wr_i & (addr_i == 2'd0);

  // Bus FSM: next state and the edge on which an access is serviced.
  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (sel_i) begin
`ifdef GRAPHITE_CMD_BRIDGE_WAITSTATE_EN
          if (is_data_wr && !can_push) begin
            state_next = ST_WAIT;
          end else begin
            state_next = ST_ACK;
            take       = 1'b1;
          end
`else
          state_next = ST_ACK;
          take       = 1'b1;
`endif
        end
      end
      ST_ACK: state_next = ST_IDLE;
`ifdef GRAPHITE_CMD_BRIDGE_WAITSTATE_EN
      ST_WAIT: begin
        if (can_push) begin
          state_next = ST_ACK;
          take       = 1'b1;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign do_push = take & is_data_wr & can_push;
  assign ctrl_wr = take & wr_i & (addr_i == 2'd2);
  assign flush   = ctrl_wr & data_in_i[0];

  // Output stage reloads when empty or consumed: RAM first, else bypass the push.
  assign refill   = ~tvalid_reg | do_pop;
  assign load_ram = ~flush & refill & (ram_cnt_reg != '0);
  assign load_byp = ~flush & refill & (ram_cnt_reg == '0) & do_push;
  assign ram_we   = ~flush & do_push & ~load_byp;

  // FIFO pointer, occupancy and output-valid next state.
  always_comb begin
    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    ram_cnt_next = ram_cnt_reg;
    tvalid_next  = tvalid_reg;
    if (flush) begin
      rd_ptr_next  = '0;
      wr_ptr_next  = '0;
      ram_cnt_next = '0;
      tvalid_next  = 1'b0;
    end else begin
      if (load_ram) rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (ram_we)   wr_ptr_next = ptr_inc(wr_ptr_reg);
      ram_cnt_next = ram_cnt_reg + LVL_W'(ram_we) - LVL_W'(load_ram);
      if (refill) tvalid_next = load_ram | load_byp;
    end
  end

  assign level_next = ram_cnt_next + LVL_W'(tvalid_next);

  // Overflow flag and interrupt enable next state.
  always_comb begin
    ovf_next = ovf_reg;
    if (ctrl_wr && data_in_i[1]) ovf_next = 1'b0;
`ifndef GRAPHITE_CMD_BRIDGE_WAITSTATE_EN
    if (take && is_data_wr && !can_push) ovf_next = 1'b1;
`endif
    irq_en_next = ctrl_wr ? data_in_i[2] : irq_en_reg;
  end

  // Read data mux; status reflects the state after the servicing edge.
  always_comb begin
    dout_next = '0;
    if (take && !wr_i) begin
      case (addr_i)
        2'd1: dout_next = {12'b0, (level_next <= LVL_LOW), ovf_next,
                           (level_next == LVL_FULL), (level_next == '0),
                           16'(level_next)};
        2'd2: dout_next = {29'b0, irq_en_next, 2'b0};
        default: dout_next = '0;
      endcase
    end
  end

  // Bus FSM state register.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  // FIFO control, output stage, flags and read data registers.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      ram_cnt_reg <= '0;
      tvalid_reg  <= 1'b0;
      tdata_reg   <= '0;
      ovf_reg     <= 1'b0;
      irq_en_reg  <= 1'b0;
      irq_reg     <= 1'b0;
      dout_reg    <= '0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      ram_cnt_reg <= ram_cnt_next;
      tvalid_reg  <= tvalid_next;
      if (load_ram)      tdata_reg <= mem[rd_ptr_reg];
      else if (load_byp) tdata_reg <= data_in_i;
      ovf_reg     <= ovf_next;
      irq_en_reg  <= irq_en_next;
      irq_reg     <= irq_en_next & (level_next <= LVL_LOW);
      dout_reg    <= dout_next;
    end
  end

  // Command RAM write port; contents are qualified by ram_cnt, so no reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_ptr_reg] <= data_in_i;
  end

  assign ack_o             = (state_reg == ST_ACK);
  assign data_out_o        = dout_reg;
  assign cmd_axis_tvalid_o = tvalid_reg;
  assign cmd_axis_tdata_o  = tdata_reg;
  assign irq_o             = irq_reg;

endmodule

// File: tb/tb_graphite_cmd_bridge.sv
// Self-checking bench for graphite_cmd_bridge: directed scenarios plus randomized
// traffic against a queue-based reference model of the command FIFO.
module tb_graphite_cmd_bridge;

  localparam int DEPTH     = 16;
  localparam int LOW_WATER = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel_i, wr_i;
  logic [1:0]  addr_i;
  logic [31:0] data_in_i, data_out_o;
  logic        ack_o, tvalid, tready, irq_o;
  logic [31:0] tdata;

  int n_checks = 0;
  int n_errors = 0;
  int n_words  = 0;
  int tready_mode = 0;   // 0 = low, 1 = high, 2 = random
  bit chk_en = 1'b0;

  // Reference model state
  logic [31:0] q[$];
  bit          m_ovf = 1'b0;
  bit          m_irq_en = 1'b0;
  bit          m_ack_phase = 1'b0;
  bit          exp_ack = 1'b0;
  bit          exp_irq = 1'b0;
  logic [31:0] exp_dout = '0;

  graphite_cmd_bridge #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
    .clk               (clk),
    .reset_n_i         (rst_n),
    .sel_i             (sel_i),
    .wr_i              (wr_i),
    .addr_i            (addr_i),
    .data_in_i         (data_in_i),
    .data_out_o        (data_out_o),
    .ack_o             (ack_o),
    .cmd_axis_tvalid_o (tvalid),
    .cmd_axis_tready_i (tready),
    .cmd_axis_tdata_o  (tdata),
    .irq_o             (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status(input int lvl, input bit ovf);
    logic [31:0] s;
    s = 32'(lvl);
    s[16] = (lvl == 0);
    s[17] = (lvl == DEPTH);
    s[18] = ovf;
    s[19] = (lvl <= LOW_WATER);
    return s;
  endfunction

  // Reference model: one update per clock edge, from the bench-driven inputs.
  initial begin
    logic [31:0] w;
    bit pop, taken;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_ovf = 0; m_irq_en = 0; m_ack_phase = 0;
        exp_ack = 0; exp_irq = 0; exp_dout = '0;
      end else begin
        pop   = (q.size() != 0) && tready;
        taken = !m_ack_phase && sel_i;
        m_ack_phase = taken;
        if (pop) begin
          w = q.pop_front();
          $display("stream word %0d data=%h", n_words, w);
          n_words++;
        end
        exp_dout = '0;
        if (taken) begin
          if (wr_i) begin
            if (addr_i == 2'd0) begin
              if (q.size() < DEPTH) q.push_back(data_in_i);
              else m_ovf = 1;
            end else if (addr_i == 2'd2) begin
              if (data_in_i[0]) q.delete();
              if (data_in_i[1]) m_ovf = 0;
              m_irq_en = data_in_i[2];
            end
          end else begin
            if (addr_i == 2'd1) exp_dout = model_status(q.size(), m_ovf);
            else if (addr_i == 2'd2) exp_dout = {29'b0, m_irq_en, 2'b0};
          end
        end
        exp_ack = taken;
        exp_irq = m_irq_en && (q.size() <= LOW_WATER);
      end
    end
  end

  // Per-cycle comparison of all outputs against the model, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("ack", ack_o, exp_ack);
        check("dout", data_out_o, exp_dout);
        check("tvalid", tvalid, q.size() != 0);
        if (q.size() != 0) check("tdata", tdata, q[0]);
        check("irq", irq_o, exp_irq);
      end
    end
  end

  // Downstream ready driver.
  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tready_mode)
        0: tready = 1'b0;
        1: tready = 1'b1;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Bounded watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One bus access; called at posedge+1, returns in the ack cycle.
  task automatic bus_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    int n;
    sel_i = 1'b1; wr_i = w; addr_i = a; data_in_i = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ack_o !== 1'b1 && n < 64);
    check("ack_seen", ack_o, 1'b1);
    rd = data_out_o;
    sel_i = 1'b0; wr_i = 1'b0; addr_i = 2'd0; data_in_i = '0;
    $display("bus %s addr=%0d data=%h rdata=%h cycles=%0d", w ? "wr" : "rd", a, d, rd, n);
  endtask

  initial begin
    logic [31:0] rd, c;
    int r;
    sel_i = 0; wr_i = 0; addr_i = 0; data_in_i = 0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ack", ack_o, 0);
    check("rst_dout", data_out_o, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_irq", irq_o, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Three words in order with tready high.
    tready_mode = 1;
    bus_xfer(1, 2'd0, 32'h11111111, rd);
    check("lat_tvalid", tvalid, 1);
    check("lat_tdata", tdata, 32'h11111111);
    bus_xfer(1, 2'd0, 32'h22222222, rd);
    bus_xfer(1, 2'd0, 32'h33333333, rd);
    idle(5);
    bus_xfer(0, 2'd1, 0, rd);
    check("t1_status", rd, 32'h00090000);
    bus_xfer(0, 2'd2, 0, rd);
    check("t1_ctrl", rd, 32'h0);
    bus_xfer(0, 2'd0, 0, rd);
    check("t1_data_rd", rd, 32'h0);

    // Overfill with tready low.
    tready_mode = 0;
    idle(2);
    for (int i = 0; i <= DEPTH; i++) bus_xfer(1, 2'd0, 32'hA0000000 + 32'(i), rd);
    bus_xfer(0, 2'd1, 0, rd);
    check("full_status", rd, 32'h00060010);
    bus_xfer(1, 2'd2, 32'h2, rd);
    bus_xfer(0, 2'd1, 0, rd);
    check("ovf_clr_status", rd, 32'h00020010);
    tready_mode = 1;
    bus_xfer(1, 2'd0, 32'h17171717, rd);
    idle(30);

    // tdata held while stalled.
    tready_mode = 0;
    idle(2);
    bus_xfer(1, 2'd0, 32'hCAFE0003, rd);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("hold_tdata", tdata, 32'hCAFE0003);
    end

    // Random ready with randomized bus traffic.
    tready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0) bus_xfer(0, 2'd1, 0, rd);
      else if (r == 1) begin
        c = '0;
        c[2] = 1'($urandom_range(0, 1));
        c[1] = 1'($urandom_range(0, 1));
        bus_xfer(1, 2'd2, c, rd);
      end else if (r == 2) bus_xfer(0, 2'd2, 0, rd);
      else if (r == 3) bus_xfer(0, 2'd3, 0, rd);
      bus_xfer(1, 2'd0, $urandom, rd);
    end
    tready_mode = 1;
    idle(40);
    bus_xfer(1, 2'd2, 32'h2, rd);
    bus_xfer(0, 2'd1, 0, rd);
    check("rand_drained", rd, 32'h00090000);

    // Flush with 8 words stored.
    tready_mode = 0;
    idle(2);
    for (int i = 0; i < 8; i++) bus_xfer(1, 2'd0, 32'hB0000000 + 32'(i), rd);
    bus_xfer(1, 2'd2, 32'h1, rd);
    check("flush_tvalid", tvalid, 0);
    bus_xfer(0, 2'd1, 0, rd);
    check("flush_status", rd, 32'h00090000);
    tready_mode = 1;
    bus_xfer(1, 2'd0, 32'hABCD0001, rd);
    check("post_flush_tdata", tdata, 32'hABCD0001);
    idle(4);

    // Low-water interrupt.
    bus_xfer(1, 2'd2, 32'h4, rd);
    check("irq_empty", irq_o, 1);
    tready_mode = 0;
    idle(2);
    for (int i = 0; i < 6; i++) bus_xfer(1, 2'd0, 32'hC0000000 + 32'(i), rd);
    check("irq_level6", irq_o, 0);
    tready_mode = 1;
    idle(12);
    check("irq_drained", irq_o, 1);
    bus_xfer(1, 2'd2, 32'h0, rd);
    check("irq_off", irq_o, 0);

    // Asynchronous reset mid-burst.
    tready_mode = 0;
    idle(2);
    for (int i = 0; i < 5; i++) bus_xfer(1, 2'd0, 32'hD0000000 + 32'(i), rd);
    check("pre_rst_tvalid", tvalid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", ack_o, 0);
    check("mid_rst_dout", data_out_o, 0);
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_tdata", tdata, 0);
    check("mid_rst_irq", irq_o, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    bus_xfer(0, 2'd1, 0, rd);
    check("post_rst_status", rd, 32'h00090000);
    bus_xfer(0, 2'd2, 0, rd);
    check("post_rst_ctrl", rd, 32'h0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
